// File: rtl/alu_pkg.sv
// Shared opcode, flag and state types for tagged_alu_pipe and its multiplier.
package alu_pkg;

    localparam int FLAGS_W = 5;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef struct packed {
        logic err;
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Radix-2 shift-add multiplier returning the low WIDTH bits of a*b.
// done pulses WIDTH cycles after start; the last partial product is folded in combinationally.
module alu_seq_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    // Adding the final bit here lets done land on the WIDTH-th cycle, not one later.
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = busy_q && (cnt_q == LAST);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
        end else if (done) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            acc_d    = product;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/tagged_alu_pipe.sv
// Tagged ALU with valid/ready request and response channels and an in-order result FIFO.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 7; otherwise opcode 7 reports err.
module tagged_alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [2:0]         opcode,
    input  logic [TAG_W-1:0]   req_tag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_result,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [FLAGS_W-1:0] rsp_flags,
    output logic               busy
);

    localparam int SHW   = $clog2(WIDTH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        flags_t           flags;
    } rsp_t;

    state_e           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    rsp_t             fifo_q [DEPTH];

    rsp_t             alu_rsp, push_data, head;
    logic             accept, push, pop, has_data;
    logic [WIDTH:0]   sum;

    assign has_data = (count_q != '0);
    assign accept   = req_valid && req_ready;
    assign pop      = has_data && rsp_ready;

    always_comb begin
        sum         = '0;
        alu_rsp     = '0;
        alu_rsp.tag = req_tag;
        case (op_e'(opcode))
            OP_ADD: begin
                sum              = {1'b0, op_a} + {1'b0, op_b};
                alu_rsp.result   = sum[WIDTH-1:0];
                alu_rsp.flags.c  = sum[WIDTH];
                alu_rsp.flags.v  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                sum              = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH + 1)'(1);
                alu_rsp.result   = sum[WIDTH-1:0];
                alu_rsp.flags.c  = sum[WIDTH];
                alu_rsp.flags.v  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_rsp.result = op_a & op_b;
            OP_OR:  alu_rsp.result = op_a | op_b;
            OP_XOR: alu_rsp.result = op_a ^ op_b;
            OP_SLL: alu_rsp.result = op_a << op_b[SHW-1:0];
            OP_SRL: alu_rsp.result = op_a >> op_b[SHW-1:0];
            OP_MUL: begin
`ifdef ALU_MUL_EN
                alu_rsp.result = '0;
`else
                alu_rsp.flags.err = 1'b1;
`endif
            end
            default: alu_rsp.result = '0;
        endcase
        alu_rsp.flags.z = (alu_rsp.result == '0);
        alu_rsp.flags.n = alu_rsp.result[WIDTH-1];
    end

`ifdef ALU_MUL_EN
    logic             mul_start, mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [TAG_W-1:0] mul_tag_q;
    rsp_t             mul_rsp;

    assign mul_start = accept && (op_e'(opcode) == OP_MUL);

    alu_seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        mul_rsp         = '0;
        mul_rsp.result  = mul_product;
        mul_rsp.tag     = mul_tag_q;
        mul_rsp.flags.z = (mul_product == '0);
        mul_rsp.flags.n = mul_product[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mul_tag_q <= '0;
        end else if (mul_start) begin
            mul_tag_q <= req_tag;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_data = alu_rsp;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef ALU_MUL_EN
                    if (op_e'(opcode) == OP_MUL) begin
                        state_d = S_MUL;
                    end else begin
                        push = 1'b1;
                    end
`else
                    push = 1'b1;
`endif
                end
            end
`ifdef ALU_MUL_EN
            // Room is guaranteed: the accept needed a free slot and nothing else pushes meanwhile.
            S_MUL: begin
                if (mul_done) begin
                    push      = 1'b1;
                    push_data = mul_rsp;
                    state_d   = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = fifo_q[rd_ptr_q];
    assign rsp_valid  = reset && has_data;
    assign rsp_result = rsp_valid ? head.result : '0;
    assign rsp_tag    = rsp_valid ? head.tag    : '0;
    assign rsp_flags  = rsp_valid ? head.flags  : '0;
    assign req_ready  = reset && (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign busy       = reset && ((state_q != S_IDLE) || has_data);

endmodule

// File: tb/tb_tagged_alu_pipe.sv
// Self-checking bench for tagged_alu_pipe: scoreboard of expected responses plus directed scenarios.
// Multiplier scenarios are compiled when ALU_MUL_EN is defined.
module tb_tagged_alu_pipe;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int D  = 4;

    typedef logic [W+TW+5-1:0] rsp_vec_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          req_valid = 1'b0;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  op_a      = '0;
    logic [W-1:0]  op_b      = '0;
    logic [2:0]    opcode    = '0;
    logic [TW-1:0] req_tag   = '0;
    logic          req_ready, rsp_valid, busy;
    logic [W-1:0]  rsp_result;
    logic [TW-1:0] rsp_tag;
    logic [4:0]    rsp_flags;

    rsp_vec_t sb[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tagged_alu_pipe #(
        .WIDTH(W),
        .TAG_W(TW),
        .DEPTH(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    // Reference: {result, tag, err, c, v, n, z}; overflow from signed range, not sign bits.
    function automatic rsp_vec_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [TW-1:0] tag);
        logic [W-1:0] r;
        logic [W:0]   full;
        logic         e, c, v;
        longint       s;
        logic [$clog2(W)-1:0] sh;
`ifdef ALU_MUL_EN
        logic [2*W-1:0] p;
`endif
        r = '0; full = '0; e = 1'b0; c = 1'b0; v = 1'b0; s = 0;
        sh = b[$clog2(W)-1:0];
        case (op)
            3'd0: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[W-1:0]; c = full[W];
                s = longint'($signed(a)) + longint'($signed(b));
            end
            3'd1: begin
                full = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = full[W-1:0]; c = full[W];
                s = longint'($signed(a)) - longint'($signed(b));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: r = a >> sh;
            default: begin
`ifdef ALU_MUL_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r = p[W-1:0];
`else
                e = 1'b1;
`endif
            end
        endcase
        if (op == 3'd0 || op == 3'd1) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {r, tag, e, c, v, r[W-1], (r == '0)};
    endfunction

    task automatic monitor();
        rsp_vec_t exp;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid && rsp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: actual result=%h tag=%h flags=%b, required no response",
                             rsp_result, rsp_tag, rsp_flags);
                end else begin
                    exp = sb.pop_front();
                    if ({rsp_result, rsp_tag, rsp_flags} !== exp) begin
                        errors++;
                        $display("FAIL rsp_scoreboard: actual result=%h tag=%h flags=%b, required result=%h tag=%h flags=%b",
                                 rsp_result, rsp_tag, rsp_flags, exp[W+TW+4:TW+5], exp[TW+4:5], exp[4:0]);
                    end
                end
            end
        end
    endtask

    // Holds the request until a cycle where req_ready is seen; returns aligned #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input bit expect_rsp, output int waits);
        req_valid = 1'b1; opcode = op; op_a = a; op_b = b; req_tag = tag;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req_ready === 1'b1) break;
            waits++;
            if (waits > 200) break;
        end
        checks++;
        if (waits > 200) begin
            errors++;
            $display("FAIL accept_timeout: actual tag=%h waited %0d cycles, required acceptance", tag, waits);
        end else if (expect_rsp) begin
            sb.push_back(model(op, a, b, tag));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d responses outstanding, required 0", sb.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; opcode = 3'd0; op_a = 32'h1; op_b = 32'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_req_ready: actual %b, required 0", req_ready);
        end
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_valid_busy: actual %b, required 00", {rsp_valid, busy});
        end
        checks++;
        if ({rsp_result, rsp_tag, rsp_flags} !== '0) begin
            errors++; $display("FAIL reset_fields: actual %h, required 0", {rsp_result, rsp_tag, rsp_flags});
        end
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL reset_release: actual ready/valid/busy=%b, required 100", {req_ready, rsp_valid, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_sub();
        int w;
        rsp_ready = 1'b1;
        send(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 4'h3, 1'b1, w);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_flags} !== {1'b1, 32'h0, 4'h3, 5'b01001}) begin
            errors++; $display("FAIL add_carry: actual v=%b r=%h t=%h f=%b, required v=1 r=00000000 t=3 f=01001",
                               rsp_valid, rsp_result, rsp_tag, rsp_flags);
        end
        @(posedge clk); #1;
        send(3'd1, 32'h8000_0000, 32'h0000_0001, 4'h5, 1'b1, w);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_flags} !== {1'b1, 32'h7FFF_FFFF, 4'h5, 5'b01100}) begin
            errors++; $display("FAIL sub_overflow: actual v=%b r=%h t=%h f=%b, required v=1 r=7fffffff t=5 f=01100",
                               rsp_valid, rsp_result, rsp_tag, rsp_flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_shift();
        int w;
        send(3'd5, 32'h0000_0001, 32'h0000_0021, 4'h6, 1'b1, w);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_flags} !== {1'b1, 32'h0000_0002, 5'b00000}) begin
            errors++; $display("FAIL sll_mask: actual v=%b r=%h f=%b, required v=1 r=00000002 f=00000",
                               rsp_valid, rsp_result, rsp_flags);
        end
        @(posedge clk); #1;
        send(3'd6, 32'h8000_0000, 32'd31, 4'h7, 1'b1, w);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result} !== {1'b1, 32'h0000_0001}) begin
            errors++; $display("FAIL srl_31: actual v=%b r=%h, required v=1 r=00000001", rsp_valid, rsp_result);
        end
        @(posedge clk); #1;
        send(3'd6, 32'hFFFF_FFFF, 32'h0000_0020, 4'h8, 1'b1, w);
        drain();
    endtask

    task automatic test_random_stream();
        int w, total;
        bit done;
        logic [2:0] op;
        logic [W-1:0] a, b;
        total = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(3'(i % 7), $urandom, $urandom, TW'(i), 1'b1, w);
            total += w;
        end
        checks++;
        if (total != 0) begin
            errors++; $display("FAIL throughput: actual %0d stall cycles, required 0", total);
        end
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    op = 3'($urandom_range(0, 6));
                    a  = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
                    b  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
                    send(op, a, b, TW'(i), 1'b1, w);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_backpressure();
        int w, total, w4;
        total = 0;
        rsp_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            send(3'd0, 32'h10 * t, 32'(t), TW'(t), 1'b1, w);
            total += w;
        end
        checks++;
        if (total != 0) begin
            errors++; $display("FAIL fill_accept: actual %0d stall cycles, required 0", total);
        end
        fork
            send(3'd0, 32'h40, 32'h4, 4'h4, 1'b1, w4);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({req_ready, rsp_valid, busy, rsp_tag} !== {1'b0, 1'b1, 1'b1, 4'h0}) begin
                        errors++; $display("FAIL full_hold: actual ready=%b valid=%b busy=%b tag=%h, required 0 1 1 0",
                                           req_ready, rsp_valid, busy, rsp_tag);
                    end
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        checks++;
        if (w4 != 4) begin
            errors++; $display("FAIL full_release: actual %0d stall cycles for tag 4, required 4", w4);
        end
        drain();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy: actual %b, required 0", busy);
        end
    endtask

    task automatic test_op7();
        int w;
`ifdef ALU_MUL_EN
        int cycles;
        bit ready_bad, seen;
        send(3'd7, 32'h0001_0000, 32'h0001_0001, 4'h9, 1'b1, w);
        cycles = 0; ready_bad = 1'b0;
        while (cycles < 40) begin
            @(negedge clk);
            if (rsp_valid) break;
            if (req_ready) ready_bad = 1'b1;
            cycles++;
        end
        checks++;
        if (cycles != W) begin
            errors++; $display("FAIL mul_latency: actual %0d cycles, required %0d", cycles, W);
        end
        checks++;
        if (ready_bad) begin
            errors++; $display("FAIL mul_ready: actual req_ready 1 during multiply, required 0");
        end
        checks++;
        if (rsp_result !== 32'h0001_0000) begin
            errors++; $display("FAIL mul_result: actual %h, required 00010000", rsp_result);
        end
        drain();
        send(3'd7, 32'h3, 32'h5, 4'hA, 1'b0, w);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b000) begin
            errors++; $display("FAIL mul_reset_outputs: actual %b, required 000", {req_ready, rsp_valid, busy});
        end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            errors++; $display("FAIL mul_abort_release: actual %b, required 100", {req_ready, rsp_valid, busy});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL mul_abort_discard: actual response after abort, required none");
        end
        @(posedge clk); #1;
`else
        send(3'd7, 32'h1234_5678, 32'h0000_9ABC, 4'h9, 1'b1, w);
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_tag, rsp_flags} !== {1'b1, 32'h0, 4'h9, 5'b10001}) begin
            errors++; $display("FAIL op7_illegal: actual v=%b r=%h t=%h f=%b, required v=1 r=00000000 t=9 f=10001",
                               rsp_valid, rsp_result, rsp_tag, rsp_flags);
        end
        @(posedge clk); #1;
        drain();
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_add_sub();
        test_shift();
        test_random_stream();
        test_backpressure();
        test_op7();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
